// File: rtl/fb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_arbiter_pkg
// Description : Shared definitions for the framebuffer RAM arbiter. Holds the
//               data-phase state encoding, the default CPU wait limit and a
//               small helper that classifies CPU data-phase states.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_arbiter_pkg;

    // Data-phase state of the shared RAM: what the access granted in the
    // previous cycle is returning this cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VGA_RD = 2'd1,
        CPU_RD = 2'd2,
        CPU_WR = 2'd3
    } dp_state_t;

    // CPU wait cycles before a forced grant.
    localparam int c_MAX_WAIT_DEFAULT = 16;

    // True while a CPU access is in its data phase (CPU is not eligible then).
    function automatic logic is_cpu_phase(input dp_state_t s);
        return (s == CPU_RD) || (s == CPU_WR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that increments on inc and saturates at all-ones.
//               Cleared by the synchronous reset.
// Ports       : clk     - clock, rising edge
//               rst     - synchronous active-high reset (clears the count)
//               inc     - increment request for this cycle
//               o_count - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fb_arbiter
// Description : Shares one single-port synchronous RAM (1-cycle read latency)
//               between VGA scan-out and a CPU. VGA has priority; a CPU that
//               has waited MAX_WAIT eligible cycles is granted anyway and the
//               displaced VGA request is reported as a miss.
// Ports       : clk, rst                      - clock / sync active-high reset
//               vga_req, vga_addr             - scan-out read request
//               vga_valid, vga_rdata          - scan-out read return
//               vga_miss, miss_count          - dropped scan-out reads
//               cpu_req/we/addr/wdata/wstrb   - CPU access, held until ack
//               cpu_ack, cpu_rdata            - CPU completion / read data
//               mem_en/we/addr/wdata, mem_rdata - RAM port
// Revision    : 1.0 - initial release
// ============================================================================
module fb_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = c_MAX_WAIT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vga_req,
    input  logic [ADDR_W-1:0]   vga_addr,
    output logic                vga_valid,
    output logic [DATA_W-1:0]   vga_rdata,
    output logic                vga_miss,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_wstrb,
    output logic                cpu_ack,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [15:0]         miss_count
);

    localparam int c_STRB_W = DATA_W / 8;
    // One extra count value so the counter can sit at MAX_WAIT, which is the
    // "limit reached" condition that forces the next eligible grant.
    localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);

    dp_state_t           r_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [DATA_W-1:0]   r_vga_rdata;
    logic [DATA_W-1:0]   r_cpu_rdata;

    logic w_cpu_elig;
    logic w_force;
    logic w_gnt_cpu;
    logic w_gnt_vga;
    logic w_miss;
    logic w_vga_valid;
    logic w_cpu_ack;
    logic w_cpu_rd_ack;

    // ------------------------------------------------------------------
    // Address-phase arbitration (combinational, grant cycle N)
    // ------------------------------------------------------------------
    always_comb begin
        w_cpu_elig = cpu_req && !is_cpu_phase(r_state);
        w_force    = w_cpu_elig && (r_wait_cnt >= c_WAIT_W'(MAX_WAIT));
        // Grants are suppressed during reset so the RAM sees no access.
        w_gnt_cpu  = !rst && w_cpu_elig && (!vga_req || w_force);
        w_gnt_vga  = !rst && vga_req && !w_gnt_cpu;
        // A CPU grant while VGA is requesting can only be a forced grant.
        w_miss     = w_gnt_cpu && vga_req;
    end

    assign mem_en    = w_gnt_vga || w_gnt_cpu;
    assign mem_we    = (w_gnt_cpu && cpu_we) ? cpu_wstrb : {c_STRB_W{1'b0}};
    assign mem_addr  = w_gnt_cpu ? cpu_addr : vga_addr;
    assign mem_wdata = cpu_wdata;
    assign vga_miss  = w_miss;

    // ------------------------------------------------------------------
    // Data phase (cycle N+1). Valid/ack are gated by rst so an access in
    // flight when reset arrives is abandoned without a completion.
    // ------------------------------------------------------------------
    assign w_vga_valid  = !rst && (r_state == VGA_RD);
    assign w_cpu_ack    = !rst && is_cpu_phase(r_state);
    assign w_cpu_rd_ack = !rst && (r_state == CPU_RD);

    // Read data is passed straight through in the valid/ack cycle and held
    // in a register afterwards, so the outputs only change with valid/ack.
    assign vga_valid = w_vga_valid;
    assign vga_rdata = w_vga_valid ? mem_rdata : r_vga_rdata;
    assign cpu_ack   = w_cpu_ack;
    assign cpu_rdata = w_cpu_rd_ack ? mem_rdata : r_cpu_rdata;

    // ------------------------------------------------------------------
    // State, wait counter and holding registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_vga_rdata <= '0;
            r_cpu_rdata <= '0;
        end else begin
            if (w_gnt_cpu) begin
                r_state <= cpu_we ? CPU_WR : CPU_RD;
            end else if (w_gnt_vga) begin
                r_state <= VGA_RD;
            end else begin
                r_state <= IDLE;
            end

            // Only eligible-but-ungranted cycles count toward starvation;
            // cycles spent in a CPU data phase neither count nor clear.
            if (!cpu_req || w_gnt_cpu) begin
                r_wait_cnt <= '0;
            end else if (w_cpu_elig && (r_wait_cnt < c_WAIT_W'(MAX_WAIT))) begin
                r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
            end

            if (r_state == VGA_RD) begin
                r_vga_rdata <= mem_rdata;
            end
            if (r_state == CPU_RD) begin
                r_cpu_rdata <= mem_rdata;
            end
        end
    end

    sat_counter #(
        .WIDTH (16)
    ) u_miss_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (w_miss),
        .o_count (miss_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_arbiter
// Description : Self-checking bench for fb_arbiter with a behavioural
//               byte-enabled single-port RAM. Directed vector table plus
//               hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_arbiter;

    localparam int c_AW = 13;
    localparam int c_DW = 32;
    localparam int c_SW = c_DW / 8;
    localparam int c_MAX_WAIT = 16;

    logic            clk;
    logic            rst;
    logic            vga_req;
    logic [c_AW-1:0] vga_addr;
    logic            vga_valid;
    logic [c_DW-1:0] vga_rdata;
    logic            vga_miss;
    logic            cpu_req;
    logic            cpu_we;
    logic [c_AW-1:0] cpu_addr;
    logic [c_DW-1:0] cpu_wdata;
    logic [c_SW-1:0] cpu_wstrb;
    logic            cpu_ack;
    logic [c_DW-1:0] cpu_rdata;
    logic            mem_en;
    logic [c_SW-1:0] mem_we;
    logic [c_AW-1:0] mem_addr;
    logic [c_DW-1:0] mem_wdata;
    logic [c_DW-1:0] mem_rdata;
    logic [15:0]     miss_count;

    int n_vec;
    int n_err;

    fb_arbiter #(
        .ADDR_W   (c_AW),
        .DATA_W   (c_DW),
        .MAX_WAIT (c_MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_valid  (vga_valid),
        .vga_rdata  (vga_rdata),
        .vga_miss   (vga_miss),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wstrb  (cpu_wstrb),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .miss_count (miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Preload pattern of the behavioural RAM.
    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'h1122_3344;
        return 32'hC0DE_0000 | i;
    endfunction

    // Behavioural single-port RAM, 1-cycle read latency, byte write enables.
    logic [c_DW-1:0] ram [0:(1<<c_AW)-1];
    logic            r_loaded = 1'b0;

    always @(posedge clk) begin
        if (!r_loaded) begin
            for (int i = 0; i < (1 << c_AW); i++) ram[i] <= init_word(i);
            r_loaded <= 1'b1;
        end else if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            for (int b = 0; b < c_SW; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vga_req   = 1'b0;
        vga_addr  = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_wstrb = '0;
    endtask

    typedef struct {
        logic            vreq;
        logic [c_AW-1:0] vaddr;
        logic            creq;
        logic            cwe;
        logic [c_AW-1:0] caddr;
        logic [c_DW-1:0] cwdata;
        logic [c_SW-1:0] cstrb;
        logic            een;
        logic [c_SW-1:0] ewe;
        logic [c_AW-1:0] eaddr;
        logic            evalid;
        logic            eack;
        logic [c_DW-1:0] erdata;
    } vec_t;

    vec_t vecs [10];

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        idle_inputs();

        // ---------------- reset state, requests active under reset ----------
        repeat (3) tick();
        vga_req = 1'b1; vga_addr = 13'h5;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h7; cpu_wstrb = 4'hF;
        #1;
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we", {28'd0, mem_we}, 32'd0);
        chk("rst_vga_miss", {31'd0, vga_miss}, 32'd0);
        chk("rst_vga_valid", {31'd0, vga_valid}, 32'd0);
        chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_vga_rdata", vga_rdata, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_miss_count", {16'd0, miss_count}, 32'd0);
        tick();
        rst = 1'b0;
        idle_inputs();
        tick();

        // ---------------- VGA streaming, 640 words -------------------------
        for (int i = 0; i <= 640; i++) begin
            if (i < 640) begin
                vga_req = 1'b1; vga_addr = c_AW'(i);
                #1;
                chk("stream_miss", {31'd0, vga_miss}, 32'd0);
                chk("stream_addr", {19'd0, mem_addr}, i);
            end else begin
                vga_req = 1'b0;
            end
            if (i > 0) begin
                chk("stream_valid", {31'd0, vga_valid}, 32'd1);
                chk("stream_rdata", vga_rdata, init_word(i - 1));
            end
            if (i < 640) tick();
        end
        tick();
        chk("stream_end_valid", {31'd0, vga_valid}, 32'd0);

        // ---------------- directed vector table ----------------------------
        //           vreq vaddr     creq cwe caddr     cwdata          strb   en we    eaddr    valid ack rdata
        vecs[0] = '{1'b0, 13'h000, 1'b0, 1'b0, 13'h000, 32'h0,         4'h0, 1'b0, 4'h0, 13'h000, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 13'h005, 1'b0, 1'b0, 13'h000, 32'h0,         4'h0, 1'b1, 4'h0, 13'h005, 1'b1, 1'b0, 32'hC0DE0005};
        vecs[2] = '{1'b0, 13'h000, 1'b1, 1'b1, 13'h100, 32'hDEADBEEF,  4'hF, 1'b1, 4'hF, 13'h100, 1'b0, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 13'h000, 1'b1, 1'b0, 13'h100, 32'h0,         4'h0, 1'b1, 4'h0, 13'h100, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 13'h007, 1'b1, 1'b0, 13'h020, 32'h0,         4'h0, 1'b1, 4'h0, 13'h007, 1'b1, 1'b0, 32'hC0DE0007};
        vecs[5] = '{1'b0, 13'h000, 1'b1, 1'b1, 13'h010, 32'hAABBCCDD,  4'h5, 1'b1, 4'h5, 13'h010, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[6] = '{1'b0, 13'h000, 1'b1, 1'b0, 13'h010, 32'h0,         4'h0, 1'b1, 4'h0, 13'h010, 1'b0, 1'b1, 32'h11BB33DD};
        vecs[7] = '{1'b0, 13'h000, 1'b1, 1'b1, 13'h030, 32'hFFFFFFFF,  4'h0, 1'b1, 4'h0, 13'h030, 1'b0, 1'b1, 32'h11BB33DD};
        vecs[8] = '{1'b0, 13'h000, 1'b1, 1'b0, 13'h030, 32'h0,         4'h0, 1'b1, 4'h0, 13'h030, 1'b0, 1'b1, 32'hC0DE0030};
        vecs[9] = '{1'b1, 13'h1FFF, 1'b0, 1'b0, 13'h000, 32'h0,        4'h0, 1'b1, 4'h0, 13'h1FFF, 1'b1, 1'b0, 32'hC0DE1FFF};

        for (int v = 0; v < 10; v++) begin
            vga_req = vecs[v].vreq; vga_addr = vecs[v].vaddr;
            cpu_req = vecs[v].creq; cpu_we = vecs[v].cwe; cpu_addr = vecs[v].caddr;
            cpu_wdata = vecs[v].cwdata; cpu_wstrb = vecs[v].cstrb;
            #1;
            chk($sformatf("vec%0d_mem_en", v), {31'd0, mem_en}, {31'd0, vecs[v].een});
            chk($sformatf("vec%0d_mem_we", v), {28'd0, mem_we}, {28'd0, vecs[v].ewe});
            if (vecs[v].een)
                chk($sformatf("vec%0d_mem_addr", v), {19'd0, mem_addr}, {19'd0, vecs[v].eaddr});
            tick();
            idle_inputs();
            #1;
            chk($sformatf("vec%0d_vga_valid", v), {31'd0, vga_valid}, {31'd0, vecs[v].evalid});
            chk($sformatf("vec%0d_cpu_ack", v), {31'd0, cpu_ack}, {31'd0, vecs[v].eack});
            if (vecs[v].evalid)
                chk($sformatf("vec%0d_vga_rdata", v), vga_rdata, vecs[v].erdata);
            if (vecs[v].eack)
                chk($sformatf("vec%0d_cpu_rdata", v), cpu_rdata, vecs[v].erdata);
            tick();
        end

        // ---------------- starvation / forced grant ------------------------
        begin
            int found;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h100;
            for (int c = 0; c <= c_MAX_WAIT; c++) begin
                vga_req = 1'b1; vga_addr = c_AW'(13'h200 + c);
                #1;
                if (c < c_MAX_WAIT) begin
                    chk("starve_vga_gnt", {19'd0, mem_addr}, 32'h200 + c);
                    chk("starve_no_miss", {31'd0, vga_miss}, 32'd0);
                end else begin
                    chk("force_cpu_gnt", {19'd0, mem_addr}, 32'h100);
                    chk("force_miss", {31'd0, vga_miss}, 32'd1);
                end
                tick();
            end
            // ack cycle: CPU ineligible, VGA granted normally
            vga_addr = 13'h300;
            #1;
            chk("force_ack", {31'd0, cpu_ack}, 32'd1);
            chk("force_rdata", cpu_rdata, 32'hDEADBEEF);
            chk("force_dropped_valid", {31'd0, vga_valid}, 32'd0);
            chk("force_miss_count", {16'd0, miss_count}, 32'd1);
            chk("ack_cycle_no_miss", {31'd0, vga_miss}, 32'd0);
            chk("ack_cycle_vga_gnt", {19'd0, mem_addr}, 32'h300);
            tick();
            // wait counter restarted: second forced grant 16 cycles later
            found = -1;
            for (int k = 0; k < 40 && found < 0; k++) begin
                vga_addr = c_AW'(13'h400 + k);
                #1;
                if (mem_en && mem_addr == 13'h100) found = k;
                tick();
            end
            chk("restart_wait", found, c_MAX_WAIT);
            cpu_req = 1'b0;
            #1;
            chk("restart_ack", {31'd0, cpu_ack}, 32'd1);
            chk("restart_miss_count", {16'd0, miss_count}, 32'd2);
            idle_inputs();
            tick();
        end

        // ---------------- held request across ack --------------------------
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h100;
        #1;
        chk("held_gnt1", {31'd0, mem_en}, 32'd1);
        tick();
        chk("held_ack1", {31'd0, cpu_ack}, 32'd1);
        chk("held_no_gnt_in_ack", {31'd0, mem_en}, 32'd0);
        tick();
        chk("held_ack_gap", {31'd0, cpu_ack}, 32'd0);
        chk("held_gnt2", {31'd0, mem_en}, 32'd1);
        chk("held_gnt2_addr", {19'd0, mem_addr}, 32'h100);
        tick();
        chk("held_ack2", {31'd0, cpu_ack}, 32'd1);
        cpu_req = 1'b0;
        tick();

        // ---------------- reset during CPU read data phase -----------------
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h010;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_no_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_mid_mem_en", {31'd0, mem_en}, 32'd0);
        tick();
        chk("rst_mid_ack_after", {31'd0, cpu_ack}, 32'd0);
        chk("rst_mid_valid", {31'd0, vga_valid}, 32'd0);
        chk("rst_mid_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_mid_vga_rdata", vga_rdata, 32'd0);
        chk("rst_mid_miss_count", {16'd0, miss_count}, 32'd0);
        rst = 1'b0;
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
